serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised bit-serial adder: adds two W-bit operands plus carry-in, one bit per clock, through a single full-adder cell and a carry flip-flop. It replaces the combinational single-bit adder primitive wherever area matters more than latency. It uses a start/busy/done handshake and holds its result until the next operation is accepted.

## Interface
Parameters:
- W, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request an operation; sampled only in IDLE or DONE.
- a  in  W  operand A; sampled on the edge that accepts start.
- b  in  W  operand B; sampled on the edge that accepts start.
- cin  in  1  carry-in; sampled on the edge that accepts start.
- sub  in  1  subtract mode; sampled with start. Present only when SERIAL_ADDER_SUB_EN is defined.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; sum and cout are valid while it is high.
- sum  out  W  result; held from done until the next accepted start.
- cout  out  1  final carry out; held with sum.

## Operation
- States:
  - IDLE: the reset state.
  - RUN: processes one bit per cycle.
  - DONE: lasts exactly 1 cycle.
- Transitions:
  - IDLE, start=1 -> RUN: load A and B shift registers, set the carry flip-flop to cin, clear the bit counter.
  - IDLE, start=0 -> stay in IDLE.
  - RUN, counter < W-1 -> RUN: full_adder(a_sh[0], b_sh[0], carry) result shifts into the sum MSB; A and B shift right; carry updates; counter increments.
  - RUN, counter == W-1 -> DONE: same bit step as above; cout takes the final carry.
  - DONE, start=1 -> RUN: same load as from IDLE, giving back-to-back operation.
  - DONE, start=0 -> IDLE.
- start is ignored during RUN. Operands are not re-sampled and no error is flagged.
- Arithmetic is unsigned modulo 2^W, and {cout, sum} = a + b + cin.
- Bit counter width is $clog2(W). It never exceeds W-1 and never wraps.
- The sum register is the shift register itself, so sum is undefined while busy=1. Consumers sample it only while done=1 or later.
- Reset asserted at any time, including mid-RUN:
  - state goes to IDLE immediately;
  - busy, done, sum, cout and the carry flip-flop all go to 0;
  - the partial result is discarded.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0.
- The edge that accepts start is edge k. busy=1 after edges k through k+W-1.
- done=1 and the result are valid after edge k+W, for one cycle. Latency is W cycles from the accepting edge.
- Throughput with back-to-back starts is one operation per W+1 cycles.
- sum and cout stay stable after done falls, until the cycle after the next accepting edge.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - the sub port exists;
  - when sub=1 at start, B is loaded inverted and carry is initialised to 1 (cin is ignored), so sum = a - b mod 2^W;
  - in that mode cout=1 means no borrow (a >= b);
  - sub=0 behaves as plain addition.
- SERIAL_ADDER_SUB_EN undefined: the sub port and the inversion logic are absent, and the block is addition-only.

## Structure
- Package serial_adder_pkg holds:
  - the state enum (IDLE, RUN, DONE), 2-bit encoding;
  - the default width constant SERIAL_ADDER_W_DEFAULT = 8.
- One sub-module, full_adder: combinational, inputs a, b, cin; outputs sum, cout. It is instantiated once in serial_adder.
- Top-level serial_adder contains the FSM, the bit counter, the A, B and sum shift registers, and the carry flip-flop.

## Test plan
- W=8; a=0x35, b=0x4A, cin=0, start pulse -> done after 8 cycles; sum=0x7F, cout=0; busy high exactly 8 cycles.
- W=8; a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Repeat with a=0x35, b=0x4A, cin=1 -> sum=0x80, cout=0.
- Start held high continuously with new operands presented each DONE cycle -> done every 9 cycles with correct results. Operands changed during RUN are ignored.
- rst asserted on the 4th RUN cycle -> all outputs 0 immediately. A following start with a=0x01, b=0x02 -> sum=0x03.
- W=16; a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1 after 16 cycles.
- With SERIAL_ADDER_SUB_EN: sub=1, a=0x10, b=0x20 -> sum=0xF0, cout=0. sub=1, a=0x20, b=0x10 -> sum=0x10, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SERIAL_ADDER_W_DEFAULT = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit combinational full adder used as the serial adder's datapath cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one full-adder cell, a carry flop and LSB-first shift registers.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b via inverted B and carry-in of 1).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int W = SERIAL_ADDER_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    sum_sh;
    logic            carry;
    logic            accept;
    logic            fa_sum;
    logic            fa_cout;
    logic [W-1:0]    b_load;
    logic            carry_load;

    assign accept = start && (state == IDLE || state == DONE);

`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Operand shift registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= a;
            b_sh <= b_load;
        end else if (state == RUN) begin
            a_sh <= {1'b0, a_sh[W-1:1]};
            b_sh <= {1'b0, b_sh[W-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            sum_sh <= '0;
            cout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        state <= RUN;
                        cnt   <= '0;
                        carry <= carry_load;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // Result bits enter at the MSB so bit 0 lands in place after W steps.
                    sum_sh <= {fa_sum, sum_sh[W-1:1]};
                    carry  <= fa_cout;
                    if (cnt == LAST) begin
                        state <= DONE;
                        cout  <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign sum = sum_sh;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at W=8 and W=16, with immediate-assertion checks.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8, cin8, sub8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;

    logic        start16, cin16, sub16;
    logic [15:0] a16, b16;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.W(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub8),
`endif
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.W(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .cin   (cin16),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub16),
`endif
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete operation on the selected instance, with latency/busy/result/hold checks.
    task automatic op(input bit wide, input logic [15:0] av, input logic [15:0] bv,
                      input logic ci, input logic sb, input logic [15:0] es,
                      input logic ec, input string tag);
        int lat, nb, w;
        bit seen;
        logic d, bz;
        w = wide ? 16 : 8;
        lat = 40;
        nb = 0;
        seen = 1'b0;
        @(negedge clk);
        if (wide) begin
            start16 = 1'b1; a16 = av; b16 = bv; cin16 = ci; sub16 = sb;
        end else begin
            start8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; cin8 = ci; sub8 = sb;
        end
        @(posedge clk);
        #1;
        start8 = 1'b0; start16 = 1'b0;
        a8 = ~a8; b8 = ~b8; cin8 = ~cin8;
        a16 = ~a16; b16 = ~b16; cin16 = ~cin16;
        for (int i = 0; i < 40; i++) begin
            if (!seen) begin
                @(negedge clk);
                d  = wide ? done16 : done8;
                bz = wide ? busy16 : busy8;
                if (d) begin
                    lat = i;
                    seen = 1'b1;
                end else if (bz) begin
                    nb++;
                end
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(w));
        chk({tag, "_busy_cycles"}, 64'(nb), 64'(w));
        chk({tag, "_sum"}, wide ? 64'(sum16) : 64'(sum8), 64'(es));
        chk({tag, "_cout"}, wide ? 64'(cout16) : 64'(cout8), 64'(ec));
        @(negedge clk);
        chk({tag, "_done_pulse"}, wide ? 64'(done16) : 64'(done8), 64'd0);
        chk({tag, "_sum_hold"}, wide ? 64'(sum16) : 64'(sum8), 64'(es));
    endtask

    initial begin
        int cnt;
        bit seen;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy8), 64'd0);
        chk("reset_done", 64'(done8), 64'd0);
        chk("reset_sum", 64'(sum8), 64'd0);
        chk("reset_cout", 64'(cout8), 64'd0);
        rst = 1'b0;

        op(1'b0, 16'h35, 16'h4A, 1'b0, 1'b0, 16'h7F, 1'b0, "add_35_4a");
        op(1'b0, 16'hFF, 16'h01, 1'b0, 1'b0, 16'h00, 1'b1, "add_ff_01");
        op(1'b0, 16'h35, 16'h4A, 1'b1, 1'b0, 16'h80, 1'b0, "add_35_4a_c1");

        // Back-to-back: start held high, new operands on each done cycle.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        @(posedge clk);
        #1;
        cnt = 40; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!seen) begin
                @(negedge clk);
                if (i == 2) begin a8 = 8'hAA; b8 = 8'hBB; end
                if (done8) begin cnt = i; seen = 1'b1; end
            end
        end
        chk("b2b_first_latency", 64'(cnt), 64'd8);
        chk("b2b_first_sum", 64'(sum8), 64'h46);
        chk("b2b_first_cout", 64'(cout8), 64'd0);
        a8 = 8'h80; b8 = 8'h81; cin8 = 1'b0;
        cnt = 40; seen = 1'b0;
        for (int i = 1; i < 40; i++) begin
            if (!seen) begin
                @(negedge clk);
                if (i == 2) begin a8 = 8'h01; b8 = 8'h01; cin8 = 1'b1; end
                if (done8) begin cnt = i; seen = 1'b1; end
            end
        end
        chk("b2b_second_period", 64'(cnt), 64'd9);
        chk("b2b_second_sum", 64'(sum8), 64'h01);
        chk("b2b_second_cout", 64'(cout8), 64'd1);
        a8 = 8'hC8; b8 = 8'h64; cin8 = 1'b0;
        cnt = 40; seen = 1'b0;
        for (int i = 1; i < 40; i++) begin
            if (!seen) begin
                @(negedge clk);
                if (i == 3) begin a8 = 8'h00; b8 = 8'h00; end
                if (done8) begin cnt = i; seen = 1'b1; end
            end
        end
        chk("b2b_third_period", 64'(cnt), 64'd9);
        chk("b2b_third_sum", 64'(sum8), 64'h2C);
        chk("b2b_third_cout", 64'(cout8), 64'd1);
        start8 = 1'b0;
        @(negedge clk);
        chk("b2b_idle_busy", 64'(busy8), 64'd0);
        chk("b2b_idle_done", 64'(done8), 64'd0);

        // Reset in the middle of an operation.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrun_busy_before_rst", 64'(busy8), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrun_rst_busy", 64'(busy8), 64'd0);
        chk("midrun_rst_done", 64'(done8), 64'd0);
        chk("midrun_rst_sum", 64'(sum8), 64'd0);
        chk("midrun_rst_cout", 64'(cout8), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        op(1'b0, 16'h01, 16'h02, 1'b0, 1'b0, 16'h03, 1'b0, "after_rst");

        op(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, "w16_all_ones");
        op(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, "w16_mixed");

`ifdef SERIAL_ADDER_SUB_EN
        op(1'b0, 16'h10, 16'h20, 1'b0, 1'b1, 16'hF0, 1'b0, "sub_borrow");
        op(1'b0, 16'h20, 16'h10, 1'b1, 1'b1, 16'h10, 1'b1, "sub_no_borrow");
        op(1'b0, 16'h35, 16'h4A, 1'b0, 1'b0, 16'h7F, 1'b0, "sub0_add");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
